// File: rtl/seg_scan_if.sv
// Bundle between a multiplexed 7-segment display scanner and the readback
// decoder: the active-low segment/select bus plus the decoded score outputs.
interface seg_scan_if;
  logic [7:0]  seg_in;        // active-low segments, bit7 = dp, bits6..0 = g..a
  logic [3:0]  sel_in;        // active-low one-cold digit select
  logic [15:0] score;         // last clean BCD score
  logic        score_valid;   // score reflects a clean, non-stale frame
  logic        score_update;  // one-cycle pulse on a new or changed score
  logic        pattern_err;   // one-cycle pulse on an undecodable glyph
  logic        scan_timeout;  // level, high while the scan is stalled

  // Display side drives the bus and observes the readback.
  modport master (
    output seg_in, sel_in,
    input  score, score_valid, score_update, pattern_err, scan_timeout
  );

  // Decoder side samples the bus and produces the readback.
  modport slave (
    input  seg_in, sel_in,
    output score, score_valid, score_update, pattern_err, scan_timeout
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Readback decoder for a multiplexed 4-digit 7-segment display. Registers the
// bus once, waits for each {sel,seg} pair to stay stable, decodes the glyph to
// BCD and reassembles the score. Bad glyphs discard the frame; a scan that
// stops producing captures is flagged as stalled.
module seg_scan_decoder #(
  parameter logic [31:0] STABLE_CYCLES  = 32'd1000,     // >= 2
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic       CLK_50M,
  input  logic       RSTn,
  seg_scan_if.slave  bus
);

  logic [7:0]  seg_q,   seg_d;
  logic [3:0]  sel_q,   sel_d;
  logic [11:0] prev_q,  prev_d;    // previous registered {sel,seg}
  logic [31:0] stab_q,  stab_d;    // consecutive identical samples minus one
  logic [31:0] idle_q,  idle_d;    // cycles since the last capture
  logic [3:0]  mask_q,  mask_d;    // digits captured in the current frame
  logic [15:0] stage_q, stage_d;   // frame being assembled
  logic        bad_q,   bad_d;     // current frame saw an undecodable glyph
  logic [15:0] score_q, score_d;
  logic        valid_q, valid_d;
  logic        update_q, update_d;
  logic        err_q,   err_d;
  logic        tmo_q,   tmo_d;

  logic        same;
  logic        sel_legal;
  logic [1:0]  sel_idx;
  logic        capture;
  logic [4:0]  dec;                 // {glyph_ok, bcd}

  // Active-low glyph to BCD; bit4 flags a recognised glyph.
  function automatic logic [4:0] decode_glyph(input logic [7:0] g);
    case (g)
      8'hC0:   decode_glyph = 5'h10;
      8'hF9:   decode_glyph = 5'h11;
      8'hA4:   decode_glyph = 5'h12;
      8'hB0:   decode_glyph = 5'h13;
      8'h99:   decode_glyph = 5'h14;
      8'h92:   decode_glyph = 5'h15;
      8'h82:   decode_glyph = 5'h16;
      8'hF8:   decode_glyph = 5'h17;
      8'h80:   decode_glyph = 5'h18;
      8'h90:   decode_glyph = 5'h19;
      default: decode_glyph = 5'h00;
    endcase
  endfunction

  // Settle detection, capture decision, frame assembly and stall tracking.
  always_comb begin
    seg_d    = bus.seg_in;
    sel_d    = bus.sel_in;
    prev_d   = {sel_q, seg_q};
    mask_d   = mask_q;
    stage_d  = stage_q;
    bad_d    = bad_q;
    score_d  = score_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    tmo_d    = tmo_q;
    idle_d   = idle_q;
    sel_legal = 1'b1;
    sel_idx   = 2'd0;

    same   = ({sel_q, seg_q} == prev_q);
    stab_d = !same ? 32'd0 : ((stab_q == 32'hFFFF_FFFF) ? stab_q : stab_q + 32'd1);

    // prev_q holds the value whose stability stab_q describes.
    case (prev_q[11:8])
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_legal = 1'b0;
    endcase

    capture = sel_legal && (stab_q == STABLE_CYCLES - 32'd1);
    dec     = decode_glyph(prev_q[7:0]);

    if (capture) begin
      stage_d[{sel_idx, 2'b00} +: 4] = dec[3:0];
      mask_d[sel_idx] = 1'b1;
      bad_d  = bad_q | ~dec[4];
      err_d  = ~dec[4];
      idle_d = 32'd0;
      tmo_d  = 1'b0;
      if (mask_d == 4'hF) begin
        if (!bad_d) begin
          score_d  = stage_d;
          valid_d  = 1'b1;
          update_d = (stage_d != score_q) || !valid_q;
        end
        mask_d = 4'h0;
        bad_d  = 1'b0;
      end
    end else if (idle_q != TIMEOUT_CYCLES) begin
      idle_d = idle_q + 32'd1;
      if (idle_d == TIMEOUT_CYCLES) begin
        tmo_d   = 1'b1;
        valid_d = 1'b0;
        mask_d  = 4'h0;
        bad_d   = 1'b0;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK_50M) begin
    if (!RSTn) begin
      seg_q    <= '0;
      sel_q    <= '0;
      prev_q   <= '0;
      stab_q   <= '0;
      idle_q   <= '0;
      mask_q   <= '0;
      stage_q  <= '0;
      bad_q    <= 1'b0;
      score_q  <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      prev_q   <= prev_d;
      stab_q   <= stab_d;
      idle_q   <= idle_d;
      mask_q   <= mask_d;
      stage_q  <= stage_d;
      bad_q    <= bad_d;
      score_q  <= score_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.score        = score_q;
  assign bus.score_valid  = valid_q;
  assign bus.score_update = update_q;
  assign bus.pattern_err  = err_q;
  assign bus.scan_timeout = tmo_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder with short settle/timeout parameters.
module tb_seg_scan_decoder;
  localparam int S = 8;
  localparam int T = 300;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #10 clk = ~clk;

  seg_scan_if bus();

  seg_scan_decoder #(.STABLE_CYCLES(32'(S)), .TIMEOUT_CYCLES(32'(T))) dut (
    .CLK_50M (clk),
    .RSTn    (rstn),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [7:0]  glyph_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [15:0] exp_q [$];
  logic [15:0] ref_score = '0;
  logic        ref_valid = 1'b0;
  logic        ref_timeout = 1'b0;
  logic [3:0]  ref_mask = '0;
  logic [15:0] ref_stage = '0;
  logic        ref_bad = 1'b0;
  logic [11:0] last_key = '0;
  int          exp_err = 0;
  int          got_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int decode_ref(input logic [7:0] g);
    for (int i = 0; i < 10; i++)
      if (glyph_tab[i] == g) return i;
    return -1;
  endfunction

  // A digit showing long enough is read back; a full set of digits forms a frame.
  task automatic model_capture(input int d, input logic [7:0] g);
    int v;
    v = decode_ref(g);
    if (v < 0) begin
      exp_err++;
      ref_bad = 1'b1;
    end else begin
      ref_stage[d*4 +: 4] = 4'(v);
    end
    ref_mask[d] = 1'b1;
    ref_timeout = 1'b0;
    if (ref_mask == 4'hF) begin
      if (!ref_bad) begin
        if (!ref_valid || ref_stage != ref_score) exp_q.push_back(ref_stage);
        ref_score = ref_stage;
        ref_valid = 1'b1;
      end
      ref_mask = '0;
      ref_bad = 1'b0;
    end
  endtask

  // Drive a digit for n clock edges; starts and ends 1 time unit after an edge.
  task automatic show(input int d, input logic [7:0] g, input int n);
    logic [3:0] one;
    logic [3:0] sel;
    one = 4'b0001;
    sel = ~(one << d);
    bus.sel_in = sel;
    bus.seg_in = g;
    if (n >= S && {sel, g} != last_key) model_capture(d, g);
    last_key = {sel, g};
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input logic [7:0] g, input int n);
    bus.sel_in = 4'hF;
    bus.seg_in = g;
    last_key = {4'hF, g};
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] g0, input logic [7:0] g1,
                       input logic [7:0] g2, input logic [7:0] g3);
    show(0, g0, S + 3);
    show(1, g1, S + 3);
    show(2, g2, S + 3);
    show(3, g3, S + 3);
  endtask

  task automatic check_levels(input string tag);
    blank(8'hFF, 6);
    check({tag, ".score"}, 32'(bus.score), 32'(ref_score));
    check({tag, ".valid"}, 32'(bus.score_valid), 32'(ref_valid));
    check({tag, ".timeout"}, 32'(bus.scan_timeout), 32'(ref_timeout));
    check({tag, ".err_count"}, 32'(got_err), 32'(exp_err));
    check({tag, ".pending_updates"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".score"}, 32'(bus.score), 32'd0);
    check({tag, ".valid"}, 32'(bus.score_valid), 32'd0);
    check({tag, ".update"}, 32'(bus.score_update), 32'd0);
    check({tag, ".err"}, 32'(bus.pattern_err), 32'd0);
    check({tag, ".timeout"}, 32'(bus.scan_timeout), 32'd0);
  endtask

  // Monitor: every update pulse consumes one expected score.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.score_update) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL update_unexpected: got score %0h expected no update", bus.score);
        end else begin
          check("update_score", 32'(bus.score), 32'(exp_q.pop_front()));
        end
      end
      if (bus.pattern_err) got_err++;
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] g [4];
    int start;
    bus.sel_in = 4'hF;
    bus.seg_in = 8'hFF;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;

    // Basic frame, repeat, and a changed ones digit
    frame(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    check_levels("frame3210");
    frame(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    check_levels("repeat3210");
    frame(8'h90, 8'hF9, 8'hA4, 8'hB0);
    check_levels("frame3219");

    // Bad glyph on digit2 discards the frame, then a clean frame
    frame(8'h90, 8'hF9, 8'hFF, 8'hB0);
    check_levels("badglyph");
    frame(8'h90, 8'hF9, 8'hA4, 8'hB0);
    check_levels("after_bad");

    // Toggling too fast never settles; exactly S stable cycles captures once
    for (int i = 0; i < 10; i++) show(0, (i % 2) ? 8'h92 : 8'h99, S - 2);
    show(0, 8'h80, S);
    blank(8'hFF, 3);
    show(1, 8'hF9, S + 2);
    show(2, 8'hA4, S + 2);
    show(3, 8'hB0, S + 2);
    check_levels("settle");

    // Randomized frames: random glyphs, occasional bad glyph or short hold
    for (int f = 0; f < 25; f++) begin
      start = $urandom_range(0, 3);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 9) == 0) g[k] = 8'($urandom);
        else g[k] = glyph_tab[$urandom_range(0, 9)];
      end
      for (int k = 0; k < 4; k++) begin
        int d;
        d = (start + k) % 4;
        show(d, g[d], ($urandom_range(0, 7) == 0) ? S - 1 : $urandom_range(S, S + 4));
        if ($urandom_range(0, 2) == 0) blank(8'($urandom), $urandom_range(1, 3));
      end
    end
    check_levels("random");

    // Stall: valid frame then a frozen blank select
    frame(8'h90, 8'hF9, 8'hA4, 8'hB0);
    check_levels("pre_stall");
    blank(8'hFF, T + 20);
    ref_timeout = 1'b1;
    ref_valid = 1'b0;
    ref_mask = '0;
    ref_bad = 1'b0;
    check_levels("stalled");
    show(0, 8'h90, S + 3);
    check_levels("resume_first");
    show(1, 8'hF9, S + 3);
    show(2, 8'hA4, S + 3);
    show(3, 8'hB0, S + 3);
    check_levels("resume_frame");

    // Reset in the middle of a frame with digits 0 and 1 captured
    show(0, 8'hC0, S + 3);
    show(1, 8'hF9, S + 3);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    ref_score = '0;
    ref_valid = 1'b0;
    ref_timeout = 1'b0;
    ref_mask = '0;
    ref_stage = '0;
    ref_bad = 1'b0;
    last_key = '0;
    rstn = 1'b1;
    show(0, 8'h99, S + 3);
    show(1, 8'h92, S + 3);
    show(2, 8'h82, S + 3);
    check_levels("partial_after_reset");
    show(3, 8'hF8, S + 3);
    check_levels("first_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
